class_key_cmp_nway: RTL and testbench
=====================================

Name: class_key_cmp_nway

Overview:
- Parametrised exact-match resolver for the classifier. Per lookup it compares NUM_WAYS value-memory entries, read on consecutive cycles, against the original key.
- It pairs the exact-match result in order with the OpenFlow TCAM result and drives one final hit/miss/err/pointer per lookup.
- It sits between the hash-bucket/value-memory stage and the flow/tunnel ID consumer.
- Generalises the fixed 4-way, hash-only compare: arbitrary way count and read latency, TCAM merge, hash-error propagation, multi-hit detection and result queuing.

Parameters:
- KEY_LEN, 276, key width in bits.
- VT_AWIDTH, 15, value/TCAM pointer width.
- NUM_WAYS, 4, candidate entries per lookup (>=1); one beat per way.
- RD_LAT, 4, cycles from a beat to its value_mem_dout_q (>=1).
- RQ_DEPTH, 4, depth of the hash-result FIFO and of the TCAM-result FIFO (power of 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pkt_strobe  in  1  first beat of a lookup
- pkt_hbkt_err  in  1  hash-bucket error; sampled with pkt_strobe
- key_orig  in  KEY_LEN  search key; sampled with pkt_strobe
- way_vld  in  1  the current beat's way is a candidate
- val_ptr  in  VT_AWIDTH  value-memory address of the current beat
- value_mem_dout_q  in  KEY_LEN  stored key; arrives RD_LAT cycles after its beat
- of_tcam_vld  in  1  TCAM result strobe, in lookup order, any timing
- of_tcam_err  in  1  TCAM error
- of_tcam_hit_miss  in  1  TCAM hit
- tcam_ptr  in  VT_AWIDTH  TCAM result pointer
- final_vld  out  1  one-cycle result strobe
- final_err  out  1  error for this lookup
- final_hit_miss  out  1  1 = hit
- final_src  out  1  0 = exact match, 1 = TCAM
- final_ptr  out  VT_AWIDTH  winning pointer; 0 on miss or error
- ovf_err  out  1  sticky: a result FIFO overflowed

Behaviour:
- Reset: all outputs 0. Both FIFOs empty. Beat counter idle. ovf_err is cleared only by reset.
- Beats:
  - pkt_strobe starts beat 0. The lookup occupies NUM_WAYS consecutive cycles. An internal counter tracks beats 1..NUM_WAYS-1.
  - way_vld and val_ptr are sampled every beat.
  - pkt_strobe during an active lookup is a protocol violation. The counter restarts, the aborted lookup is discarded, and ovf_err sets.
- Alignment:
  - beat_vld, way_vld, val_ptr and beat index are delayed RD_LAT stages.
  - key_orig and pkt_hbkt_err are captured per lookup into a key pipeline deep enough to cover RD_LAT+NUM_WAYS cycles. The compare therefore uses the key of the lookup that owns the beat.
- Compare:
  - Registered: match = aligned beat_vld & way_vld & (value_mem_dout_q == key).
  - Accumulate per lookup: hit flag, pointer of the first match, and multi = second match seen.
- Hash result: complete on the aligned last beat, i.e. S+RD_LAT+NUM_WAYS, where S is the pkt_strobe cycle. It is pushed into the hash FIFO as {hbkt_err, multi, hit, ptr}.
- TCAM FIFO: of_tcam_vld pushes {err, hit, ptr}.
- Push into a full FIFO: the entry is dropped and ovf_err sets.
- Merge: when both FIFO heads are present, pop both the same cycle. final_vld pulses the next cycle.
  - err = hbkt_err | multi | tcam_err. On err: hit_miss=0, ptr=0, src=0.
  - Else exact hit -> hit_miss=1, src=0, ptr = exact ptr (exact wins over TCAM).
  - Else TCAM hit -> hit_miss=1, src=1, ptr = tcam ptr.
  - Else miss, ptr=0.
- Latency: with the TCAM result already queued, final_vld = S+RD_LAT+NUM_WAYS+1. Otherwise final_vld is the cycle after of_tcam_vld.
- Simultaneous push and pop on the same FIFO is legal, including when full. Back-to-back lookups every NUM_WAYS cycles sustain one result per NUM_WAYS cycles.
- Outputs other than final_vld hold their last value between strobes.
- Reset mid-operation flushes all pipelines and FIFOs; no final_vld is produced for in-flight lookups.

Optional Feature:
- CLASS_KEY_CMP_STATS_EN defined:
  - Adds 32-bit saturating counters stat_exact_hit, stat_tcam_hit, stat_miss, stat_err (output ports).
  - Each increments on final_vld per the resolved outcome.
  - Counters clear on reset and on input stat_clr (1 bit).
- Undefined: the stat ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- NUM_WAYS=4, RD_LAT=4, key K; way 2 value equals K with val_ptr=0x0123; TCAM miss queued first -> final_vld at S+9, hit_miss=1, src=0, ptr=0x0123, err=0.
- No way matches; TCAM hit ptr=0x7FFF arrives at S+20 -> final_vld at S+21, hit_miss=1, src=1, ptr=0x7FFF.
- Ways 0 and 3 both equal K -> err=1, hit_miss=0, ptr=0. Repeat with pkt_hbkt_err=1 and no match -> err=1.
- Five back-to-back lookups with alternating match/miss and TCAM held off, RQ_DEPTH=4 -> fifth hash result dropped, ovf_err=1. The first four resolve in order when the TCAM results arrive.
- way_vld=0 on a beat whose value_mem_dout_q equals K -> no match counted, final miss.
- Assert rst_n=0 two cycles after pkt_strobe -> no final_vld afterward, outputs 0, ovf_err=0. With CLASS_KEY_CMP_STATS_EN defined, counters read 0.

Source files
------------

// File: rtl/class_key_cmp_nway.sv
// class_key_cmp_nway: N-way exact-match resolver merged in order with the TCAM result.
// Latency: final_vld at S+RD_LAT+NUM_WAYS+1 when the TCAM result is already queued,
// otherwise one cycle after of_tcam_vld. There is no backpressure; a push into a full
// result queue drops that entry and sets the sticky ovf_err.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   pkt_strobe, pkt_hbkt_err,   lookup start (beat 0), hash-bucket error and key,
//   key_orig                    all sampled with pkt_strobe
//   way_vld, val_ptr            per-beat candidate flag and value-memory address
//   value_mem_dout_q            stored key, arrives RD_LAT cycles after its beat
//   of_tcam_*, tcam_ptr         TCAM result, delivered in lookup order with any timing
//   final_*                     resolved result; final_vld is a one-cycle strobe
//   ovf_err                     sticky: result queue overflow or restarted lookup
// Optional: define CLASS_KEY_CMP_STATS_EN to add stat_clr and four saturating
// 32-bit outcome counters.
module class_key_cmp_nway #(
  parameter int KEY_LEN   = 276,
  parameter int VT_AWIDTH = 15,
  parameter int NUM_WAYS  = 4,
  parameter int RD_LAT    = 4,
  parameter int RQ_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkt_strobe,
  input  logic                 pkt_hbkt_err,
  input  logic [KEY_LEN-1:0]   key_orig,
  input  logic                 way_vld,
  input  logic [VT_AWIDTH-1:0] val_ptr,
  input  logic [KEY_LEN-1:0]   value_mem_dout_q,
  input  logic                 of_tcam_vld,
  input  logic                 of_tcam_err,
  input  logic                 of_tcam_hit_miss,
  input  logic [VT_AWIDTH-1:0] tcam_ptr,
  output logic                 final_vld,
  output logic                 final_err,
  output logic                 final_hit_miss,
  output logic                 final_src,
  output logic [VT_AWIDTH-1:0] final_ptr,
  output logic                 ovf_err
`ifdef CLASS_KEY_CMP_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [31:0]          stat_exact_hit,
  output logic [31:0]          stat_tcam_hit,
  output logic [31:0]          stat_miss,
  output logic [31:0]          stat_err
`endif
);

  localparam int CW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int PW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  // Queue entry layout shared by both queues: {err, multi, hit, ptr}.
  // TCAM entries carry multi = 0.
  localparam int HW = VT_AWIDTH + 3;

  // ---------------- beat generation ----------------
  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] b_idx;
  logic          b_vld, b_last, abort;

  assign b_idx  = pkt_strobe ? '0 : cnt_q;
  assign b_vld  = pkt_strobe || busy_q;
  assign b_last = b_vld && (b_idx == CW'(NUM_WAYS - 1));
  // A strobe during a lookup restarts the counter. The old lookup never
  // reaches its last beat, so it never produces a hash result.
  assign abort  = pkt_strobe && busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (pkt_strobe) begin
      busy_q <= (NUM_WAYS > 1);
      cnt_q  <= CW'(1);
    end else if (busy_q) begin
      if (cnt_q == CW'(NUM_WAYS - 1)) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // ---------------- RD_LAT alignment pipeline ----------------
  logic [RD_LAT-1:0]    dl_vld_q, dl_first_q, dl_last_q, dl_way_q, dl_herr_q;
  logic [VT_AWIDTH-1:0] dl_ptr_q [RD_LAT];
  logic [KEY_LEN-1:0]   dl_key_q [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld_q   <= '0;
      dl_first_q <= '0;
      dl_last_q  <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        dl_vld_q[i]   <= dl_vld_q[i-1];
        dl_first_q[i] <= dl_first_q[i-1];
        dl_last_q[i]  <= dl_last_q[i-1];
      end
      dl_vld_q[0]   <= b_vld;
      dl_first_q[0] <= pkt_strobe;
      dl_last_q[0]  <= b_last;
    end
  end

  // Key and hash error travel alongside beat 0 only; later beats reuse the
  // copy latched when beat 0 is aligned, so each beat compares against its
  // own lookup's key.
  always_ff @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) begin
      dl_way_q[i]  <= dl_way_q[i-1];
      dl_herr_q[i] <= dl_herr_q[i-1];
      dl_ptr_q[i]  <= dl_ptr_q[i-1];
      dl_key_q[i]  <= dl_key_q[i-1];
    end
    dl_way_q[0]  <= way_vld;
    dl_herr_q[0] <= pkt_hbkt_err;
    dl_ptr_q[0]  <= val_ptr;
    dl_key_q[0]  <= key_orig;
  end

  logic               a_vld, a_first;
  logic [KEY_LEN-1:0] cur_key_q, key_cmp;
  logic               cur_herr_q, herr_cmp;

  assign a_vld    = dl_vld_q[RD_LAT-1];
  assign a_first  = dl_first_q[RD_LAT-1];
  assign key_cmp  = a_first ? dl_key_q[RD_LAT-1] : cur_key_q;
  assign herr_cmp = a_first ? dl_herr_q[RD_LAT-1] : cur_herr_q;

  always_ff @(posedge clk) begin
    if (a_vld && a_first) begin
      cur_key_q  <= dl_key_q[RD_LAT-1];
      cur_herr_q <= dl_herr_q[RD_LAT-1];
    end
  end

  // ---------------- registered compare + accumulate ----------------
  logic                 m_vld_q, m_first_q, m_last_q, m_hit_q, m_herr_q;
  logic [VT_AWIDTH-1:0] m_ptr_q;
  logic                 acc_hit_q, acc_multi_q;
  logic [VT_AWIDTH-1:0] acc_ptr_q;
  logic                 base_hit, base_multi, nxt_hit, nxt_multi;
  logic [VT_AWIDTH-1:0] base_ptr, nxt_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld_q   <= 1'b0;
      m_first_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_hit_q   <= 1'b0;
      m_herr_q  <= 1'b0;
      m_ptr_q   <= '0;
    end else begin
      m_vld_q   <= a_vld;
      m_first_q <= a_vld && a_first;
      m_last_q  <= a_vld && dl_last_q[RD_LAT-1];
      m_hit_q   <= a_vld && dl_way_q[RD_LAT-1] && (value_mem_dout_q == key_cmp);
      m_herr_q  <= herr_cmp;
      m_ptr_q   <= dl_ptr_q[RD_LAT-1];
    end
  end

  // Beat 0 starts from a clean slate; the first match keeps its pointer.
  assign base_hit   = m_first_q ? 1'b0 : acc_hit_q;
  assign base_multi = m_first_q ? 1'b0 : acc_multi_q;
  assign base_ptr   = m_first_q ? '0   : acc_ptr_q;
  assign nxt_hit    = base_hit || m_hit_q;
  assign nxt_multi  = base_multi || (base_hit && m_hit_q);
  assign nxt_ptr    = base_hit ? base_ptr : (m_hit_q ? m_ptr_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hit_q   <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_ptr_q   <= '0;
    end else if (m_vld_q) begin
      acc_hit_q   <= nxt_hit;
      acc_multi_q <= nxt_multi;
      acc_ptr_q   <= nxt_ptr;
    end
  end

  // ---------------- result queues (0 = hash, 1 = TCAM) ----------------
  // An empty queue presents its incoming entry as head, so a push and pop in
  // the same cycle bypasses storage; this gives the one-cycle merge latency.
  logic          f_push     [2];
  logic [HW-1:0] f_wdat     [2];
  logic          f_head_vld [2];
  logic [HW-1:0] f_head     [2];
  logic          f_ovf      [2];
  logic          pop;

  assign f_push[0] = m_vld_q && m_last_q;
  assign f_wdat[0] = {m_herr_q, nxt_multi, nxt_hit, nxt_ptr};
  assign f_push[1] = of_tcam_vld;
  assign f_wdat[1] = {of_tcam_err, 1'b0, of_tcam_hit_miss, tcam_ptr};
  assign pop       = f_head_vld[0] && f_head_vld[1];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_rq
    logic [HW-1:0] mem_q [RQ_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;
    logic          empty, full, wr_en, rd_en;

    assign empty         = (cnt_q == '0);
    assign full          = (cnt_q == (PW+1)'(RQ_DEPTH));
    assign f_head_vld[g] = !empty || f_push[g];
    assign f_head[g]     = empty ? f_wdat[g] : mem_q[rd_q];
    assign rd_en         = pop && !empty;
    assign wr_en         = f_push[g] && !(empty && pop) && (!full || pop);
    assign f_ovf[g]      = f_push[g] && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (wr_en) wr_q <= ptr_inc(wr_q);
        if (rd_en) rd_q <= ptr_inc(rd_q);
        if (wr_en && !rd_en)      cnt_q <= cnt_q + 1'b1;
        else if (rd_en && !wr_en) cnt_q <= cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q] <= f_wdat[g];
    end
  end

  // ---------------- merge ----------------
  logic res_err, h_hit, t_hit;

  assign res_err = f_head[0][HW-1] || f_head[0][HW-2] || f_head[1][HW-1] || f_head[1][HW-2];
  assign h_hit   = f_head[0][HW-3];
  assign t_hit   = f_head[1][HW-3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      final_vld      <= 1'b0;
      final_err      <= 1'b0;
      final_hit_miss <= 1'b0;
      final_src      <= 1'b0;
      final_ptr      <= '0;
      ovf_err        <= 1'b0;
    end else begin
      final_vld <= pop;
      if (pop) begin
        final_err      <= res_err;
        final_hit_miss <= !res_err && (h_hit || t_hit);
        final_src      <= !res_err && !h_hit && t_hit;
        final_ptr      <= res_err ? '0 :
                          h_hit   ? f_head[0][VT_AWIDTH-1:0] :
                          t_hit   ? f_head[1][VT_AWIDTH-1:0] : '0;
      end
      if (abort || f_ovf[0] || f_ovf[1]) ovf_err <= 1'b1;
    end
  end

`ifdef CLASS_KEY_CMP_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_exact_hit <= '0;
      stat_tcam_hit  <= '0;
      stat_miss      <= '0;
      stat_err       <= '0;
    end else if (stat_clr) begin
      stat_exact_hit <= '0;
      stat_tcam_hit  <= '0;
      stat_miss      <= '0;
      stat_err       <= '0;
    end else if (final_vld) begin
      if (final_err)           stat_err       <= sat_inc(stat_err);
      else if (!final_hit_miss) stat_miss     <= sat_inc(stat_miss);
      else if (final_src)      stat_tcam_hit  <= sat_inc(stat_tcam_hit);
      else                     stat_exact_hit <= sat_inc(stat_exact_hit);
    end
  end
`endif

endmodule

// File: tb/tb_class_key_cmp_nway.sv
// Self-checking bench for class_key_cmp_nway: table vectors, randomized
// lookups against a reference model, and hand-written latency, overflow,
// abort and reset sequences.
module tb_class_key_cmp_nway;
  localparam int KL = 276;
  localparam int AW = 15;
  localparam int NW = 4;
  localparam int RL = 4;
  localparam int RQ = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pkt_strobe, pkt_hbkt_err, way_vld;
  logic [KL-1:0] key_orig, value_mem_dout_q;
  logic [AW-1:0] val_ptr, tcam_ptr, final_ptr;
  logic          of_tcam_vld, of_tcam_err, of_tcam_hit_miss;
  logic          final_vld, final_err, final_hit_miss, final_src, ovf_err;
`ifdef CLASS_KEY_CMP_STATS_EN
  logic          stat_clr;
  logic [31:0]   stat_exact_hit, stat_tcam_hit, stat_miss, stat_err;
`endif

  always #5 clk = ~clk;

  class_key_cmp_nway #(.KEY_LEN(KL), .VT_AWIDTH(AW), .NUM_WAYS(NW), .RD_LAT(RL), .RQ_DEPTH(RQ)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_strobe(pkt_strobe), .pkt_hbkt_err(pkt_hbkt_err),
    .key_orig(key_orig), .way_vld(way_vld), .val_ptr(val_ptr),
    .value_mem_dout_q(value_mem_dout_q), .of_tcam_vld(of_tcam_vld),
    .of_tcam_err(of_tcam_err), .of_tcam_hit_miss(of_tcam_hit_miss), .tcam_ptr(tcam_ptr),
    .final_vld(final_vld), .final_err(final_err), .final_hit_miss(final_hit_miss),
    .final_src(final_src), .final_ptr(final_ptr), .ovf_err(ovf_err)
`ifdef CLASS_KEY_CMP_STATS_EN
    , .stat_clr(stat_clr), .stat_exact_hit(stat_exact_hit), .stat_tcam_hit(stat_tcam_hit),
    .stat_miss(stat_miss), .stat_err(stat_err)
`endif
  );

  typedef struct {
    int            cyc;
    logic          err;
    logic          hit;
    logic          src;
    logic [AW-1:0] ptr;
  } res_t;

  typedef struct {
    logic [3:0]    vld;
    logic [3:0]    mt;
    logic          herr;
    logic          terr;
    logic          thit;
    logic [AW-1:0] tptr;
    logic          e_err;
    logic          e_hit;
    logic          e_src;
    logic [AW-1:0] e_ptr;
  } vec_t;

  res_t          res_q[$];
  res_t          exp_q[$];
  res_t          mon_r;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [KL-1:0] hist [RL];
  logic [KL-1:0] beat_val;

  // Collect every result strobe with the cycle it was seen in.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && final_vld === 1'b1) begin
      mon_r.cyc = cyc;
      mon_r.err = final_err;
      mon_r.hit = final_hit_miss;
      mon_r.src = final_src;
      mon_r.ptr = final_ptr;
      res_q.push_back(mon_r);
    end
  end

  function automatic logic [KL-1:0] rand_key();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
    return t[KL-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Idle cycle: garbage on every qualified input.
  task automatic idle();
    pkt_strobe       = 1'b0;
    pkt_hbkt_err     = 1'($urandom);
    key_orig         = rand_key();
    way_vld          = 1'($urandom);
    val_ptr          = AW'($urandom);
    beat_val         = rand_key();
    of_tcam_vld      = 1'b0;
    of_tcam_err      = 1'($urandom);
    of_tcam_hit_miss = 1'($urandom);
    tcam_ptr         = AW'($urandom);
  endtask

  // Advance one clock; the value memory returns each beat's word RL cycles later.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = RL - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = beat_val;
    value_mem_dout_q = hist[RL-1];
    idle();
  endtask

  task automatic run_lookup(input logic [KL-1:0] k, input logic [3:0] vld, input logic [3:0] mt,
                            input logic herr, input logic [AW-1:0] pbase, input int nb,
                            input logic tc_en, input logic terr, input logic thit,
                            input logic [AW-1:0] tptr);
    for (int b = 0; b < nb; b++) begin
      pkt_strobe = (b == 0);
      if (b == 0) begin
        key_orig     = k;
        pkt_hbkt_err = herr;
      end
      way_vld  = vld[b];
      val_ptr  = pbase + AW'(b);
      beat_val = mt[b] ? k : (k ^ (rand_key() | KL'(1)));
      if (tc_en && b == 0) begin
        of_tcam_vld      = 1'b1;
        of_tcam_err      = terr;
        of_tcam_hit_miss = thit;
        tcam_ptr         = tptr;
      end
      tick();
    end
  endtask

  task automatic push_tcam(input logic terr, input logic thit, input logic [AW-1:0] tptr);
    of_tcam_vld      = 1'b1;
    of_tcam_err      = terr;
    of_tcam_hit_miss = thit;
    tcam_ptr         = tptr;
    tick();
  endtask

  // Reference: list the matching candidates, then apply the resolution rules.
  function automatic res_t model(input logic [3:0] vld, input logic [3:0] mt, input logic herr,
                                 input logic [AW-1:0] pbase, input logic terr,
                                 input logic thit, input logic [AW-1:0] tptr);
    logic [AW-1:0] hits[$];
    res_t r;
    for (int b = 0; b < NW; b++)
      if (vld[b] && mt[b]) hits.push_back(pbase + AW'(b));
    r.cyc = 0;
    r.err = herr || terr || (hits.size() > 1);
    r.hit = 1'b0; r.src = 1'b0; r.ptr = '0;
    if (!r.err && hits.size() == 1) begin
      r.hit = 1'b1; r.ptr = hits[0];
    end else if (!r.err && thit) begin
      r.hit = 1'b1; r.src = 1'b1; r.ptr = tptr;
    end
    return r;
  endfunction

  task automatic wait_results(input int n, input string nm);
    int b = 0;
    while (res_q.size() < n && b < 300) begin
      tick();
      b++;
    end
    chk({nm, " count"}, 64'(res_q.size()), 64'(n));
  endtask

  task automatic take(output res_t r);
    if (res_q.size() > 0) r = res_q.pop_front();
    else begin
      r.cyc = -1; r.err = 1'bx; r.hit = 1'bx; r.src = 1'bx; r.ptr = 'x;
    end
  endtask

  task automatic cmp_res(input string nm, input res_t r, input logic e_err, input logic e_hit,
                         input logic e_src, input logic [AW-1:0] e_ptr);
    chk({nm, " err"}, 64'(r.err), 64'(e_err));
    chk({nm, " hit"}, 64'(r.hit), 64'(e_hit));
    chk({nm, " src"}, 64'(r.src), 64'(e_src));
    chk({nm, " ptr"}, 64'(r.ptr), 64'(e_ptr));
  endtask

  task automatic settle_empty(input string nm);
    for (int i = 0; i < 15; i++) tick();
    chk({nm, " leftover"}, 64'(res_q.size()), 64'd0);
    res_q.delete();
  endtask

  vec_t tbl[12];

  initial begin
    logic [KL-1:0] k;
    res_t          r, e;
    int            s;

    tbl[0]  = '{4'hF, 4'h4, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b0, 15'h0102};
    tbl[1]  = '{4'hF, 4'h9, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b0, 15'h0000};
    tbl[2]  = '{4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b0, 15'h0000};
    tbl[3]  = '{4'hB, 4'h4, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 15'h0000};
    tbl[4]  = '{4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 15'h2222, 1'b0, 1'b1, 1'b1, 15'h2222};
    tbl[5]  = '{4'hF, 4'h2, 1'b0, 1'b0, 1'b1, 15'h3333, 1'b0, 1'b1, 1'b0, 15'h0101};
    tbl[6]  = '{4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b0, 15'h0000};
    tbl[7]  = '{4'hF, 4'h1, 1'b0, 1'b1, 1'b1, 15'h4444, 1'b1, 1'b0, 1'b0, 15'h0000};
    tbl[8]  = '{4'h8, 4'h8, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b0, 15'h0103};
    tbl[9]  = '{4'hF, 4'h4, 1'b1, 1'b0, 1'b1, 15'h5555, 1'b1, 1'b0, 1'b0, 15'h0000};
    tbl[10] = '{4'h6, 4'hF, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b0, 15'h0000};
    tbl[11] = '{4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 15'h7FFF, 1'b0, 1'b1, 1'b1, 15'h7FFF};

    rst_n = 1'b0;
`ifdef CLASS_KEY_CMP_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < RL; i++) hist[i] = rand_key();
    value_mem_dout_q = rand_key();
    idle();
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("reset final_vld", 64'(final_vld), 64'd0);
    chk("reset final_err", 64'(final_err), 64'd0);
    chk("reset final_hit_miss", 64'(final_hit_miss), 64'd0);
    chk("reset final_src", 64'(final_src), 64'd0);
    chk("reset final_ptr", 64'(final_ptr), 64'd0);
    chk("reset ovf_err", 64'(ovf_err), 64'd0);

    // Exact hit on way 2 with the TCAM miss queued first: S+RL+NW+1
    push_tcam(1'b0, 1'b0, 15'h0);
    k = rand_key();
    s = cyc;
    run_lookup(k, 4'hF, 4'h4, 1'b0, 15'h0121, NW, 1'b0, 1'b0, 1'b0, 15'h0);
    wait_results(1, "exact");
    take(r);
    chk("exact latency", 64'(r.cyc), 64'(s + RL + NW + 1));
    cmp_res("exact", r, 1'b0, 1'b1, 1'b0, 15'h0123);
    settle_empty("exact");

    // No match; TCAM hit arrives late at S+20 -> result at S+21
    k = rand_key();
    s = cyc;
    run_lookup(k, 4'hF, 4'h0, 1'b0, 15'h0200, NW, 1'b0, 1'b0, 1'b0, 15'h0);
    while (cyc < s + 20) tick();
    push_tcam(1'b0, 1'b1, 15'h7FFF);
    wait_results(1, "tcam");
    take(r);
    chk("tcam latency", 64'(r.cyc), 64'(s + 21));
    cmp_res("tcam", r, 1'b0, 1'b1, 1'b1, 15'h7FFF);
    settle_empty("tcam");

    // Table vectors, back to back, TCAM result with beat 0
    foreach (tbl[i]) begin
      run_lookup(rand_key(), tbl[i].vld, tbl[i].mt, tbl[i].herr, 15'h0100, NW,
                 1'b1, tbl[i].terr, tbl[i].thit, tbl[i].tptr);
    end
    wait_results(12, "tbl");
    foreach (tbl[i]) begin
      take(r);
      cmp_res($sformatf("tbl%0d", i), r, tbl[i].e_err, tbl[i].e_hit, tbl[i].e_src, tbl[i].e_ptr);
    end
    settle_empty("tbl");

    // Randomized lookups against the reference model
    for (int i = 0; i < 30; i++) begin
      logic [3:0]    vld, mt;
      logic          herr, terr, thit;
      logic [AW-1:0] pb, tp;
      vld  = 4'($urandom);
      mt   = 4'($urandom);
      herr = ($urandom_range(0, 7) == 0);
      terr = ($urandom_range(0, 7) == 0);
      thit = 1'($urandom);
      pb   = AW'($urandom);
      tp   = AW'($urandom);
      exp_q.push_back(model(vld, mt, herr, pb, terr, thit, tp));
      run_lookup(rand_key(), vld, mt, herr, pb, NW, 1'b1, terr, thit, tp);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    wait_results(30, "rnd");
    for (int i = 0; i < 30; i++) begin
      take(r);
      e = exp_q.pop_front();
      cmp_res($sformatf("rnd%0d", i), r, e.err, e.hit, e.src, e.ptr);
    end
    settle_empty("rnd");

    // Five back-to-back lookups with the TCAM held off: fifth hash result dropped
    for (int i = 0; i < 5; i++)
      run_lookup(rand_key(), 4'hF, (i % 2 == 0) ? 4'h2 : 4'h0, 1'b0, 15'h0300, NW,
                 1'b0, 1'b0, 1'b0, 15'h0);
    for (int i = 0; i < 12; i++) tick();
    chk("ovf ovf_err", 64'(ovf_err), 64'd1);
    chk("ovf held", 64'(res_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) push_tcam(1'b0, 1'b0, 15'h0);
    wait_results(4, "ovf");
    for (int i = 0; i < 4; i++) begin
      take(r);
      if (i % 2 == 0) cmp_res($sformatf("ovf%0d", i), r, 1'b0, 1'b1, 1'b0, 15'h0301);
      else            cmp_res($sformatf("ovf%0d", i), r, 1'b0, 1'b0, 1'b0, 15'h0000);
    end
    settle_empty("ovf");

    // Reset two cycles after pkt_strobe flushes everything
    push_tcam(1'b0, 1'b0, 15'h0);
    run_lookup(rand_key(), 4'hF, 4'h1, 1'b0, 15'h0400, 2, 1'b0, 1'b0, 1'b0, 15'h0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("rst results", 64'(res_q.size()), 64'd0);
    chk("rst final_vld", 64'(final_vld), 64'd0);
    chk("rst final_err", 64'(final_err), 64'd0);
    chk("rst final_hit_miss", 64'(final_hit_miss), 64'd0);
    chk("rst final_src", 64'(final_src), 64'd0);
    chk("rst final_ptr", 64'(final_ptr), 64'd0);
    chk("rst ovf_err", 64'(ovf_err), 64'd0);
`ifdef CLASS_KEY_CMP_STATS_EN
    chk("rst stat_exact_hit", 64'(stat_exact_hit), 64'd0);
    chk("rst stat_tcam_hit", 64'(stat_tcam_hit), 64'd0);
    chk("rst stat_miss", 64'(stat_miss), 64'd0);
    chk("rst stat_err", 64'(stat_err), 64'd0);
`endif
    res_q.delete();

    // Strobe during an active lookup: first lookup discarded, ovf_err sets
    push_tcam(1'b0, 1'b0, 15'h0);
    run_lookup(rand_key(), 4'hF, 4'h1, 1'b0, 15'h0500, 2, 1'b0, 1'b0, 1'b0, 15'h0);
    run_lookup(rand_key(), 4'hF, 4'h8, 1'b0, 15'h0200, NW, 1'b0, 1'b0, 1'b0, 15'h0);
    wait_results(1, "abort");
    take(r);
    cmp_res("abort", r, 1'b0, 1'b1, 1'b0, 15'h0203);
    chk("abort ovf_err", 64'(ovf_err), 64'd1);
    settle_empty("abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
